// File: rtl/vip_pkg.sv
// Shared widths, pixel type and the gradient absolute-value helper used by the
// Sobel edge detector.
package vip_pkg;

  localparam int PIX_W    = 8;
  localparam int GRAD_W   = 11;
  localparam int MAG_W    = 11;
  localparam int MAG2_W   = 21;
  localparam int PIPE_LAT = 5;

  typedef logic [PIX_W-1:0] pix_t;

  // |g| of a signed gradient; the range is +/-1020, so the result always fits GRAD_W-1 bits
  function automatic logic [GRAD_W-2:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    logic [GRAD_W-1:0] n;
    n = g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
    return n[GRAD_W-2:0];
  endfunction

endpackage

// File: rtl/sobel_matrix_3x3.sv
// 3x3 window generator: pixel/line counters, two line buffers, zero-padding
// masks and window registers (pipeline stage S1).
module sobel_matrix_3x3
  import vip_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync_i,
  input  logic             href_i,
  input  logic             clken_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] p11_o,
  output logic [PIX_W-1:0] p12_o,
  output logic [PIX_W-1:0] p13_o,
  output logic [PIX_W-1:0] p21_o,
  output logic [PIX_W-1:0] p22_o,
  output logic [PIX_W-1:0] p23_o,
  output logic [PIX_W-1:0] p31_o,
  output logic [PIX_W-1:0] p32_o,
  output logic [PIX_W-1:0] p33_o,
  output logic             vsync_o,
  output logic             href_o,
  output logic             clken_o
);

  localparam int COL_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int ROW_W = $clog2(IMG_VDISP + 1);

  logic [COL_W-1:0]           col_q, col_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic                       href_q, frame_ok_q;
  logic [2:0][2:0][PIX_W-1:0] win_q;
  pix_t                       lb1_mem [IMG_HDISP];
  pix_t                       lb2_mem [IMG_HDISP];
  pix_t                       row1_new, row2_new;

  always_comb begin
    col_d = col_q;
    if (!href_i)       col_d = '0;
    else if (clken_i)  col_d = col_q + 1'b1;
    row_d = row_q;
    if (!vsync_i)              row_d = '0;
    else if (href_q && !href_i) row_d = row_q + 1'b1;
  end

  // Rows above the frame top read as zero; until a vblank has been seen after
  // reset the row count is meaningless, so both upper rows stay masked.
  assign row2_new = (frame_ok_q && row_q >= ROW_W'(1)) ? lb1_mem[col_q] : '0;
  assign row1_new = (frame_ok_q && row_q >= ROW_W'(2)) ? lb2_mem[col_q] : '0;

  always_ff @(posedge clk) begin
    if (href_i && clken_i) begin
      lb1_mem[col_q] <= pix_i;
      lb2_mem[col_q] <= lb1_mem[col_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      href_q     <= 1'b0;
      frame_ok_q <= 1'b0;
      win_q      <= '0;
      {vsync_o, href_o, clken_o} <= 3'b000;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      href_q <= href_i;
      if (!vsync_i) frame_ok_q <= 1'b1;
      {vsync_o, href_o, clken_o} <= {vsync_i, href_i, clken_i};
      // cleared columns provide the left-edge zero padding of every line
      if (!href_i) begin
        win_q <= '0;
      end else if (clken_i) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= row1_new;
        win_q[1][2] <= row2_new;
        win_q[2][2] <= pix_i;
      end
    end
  end

  assign p11_o = win_q[0][0];
  assign p12_o = win_q[0][1];
  assign p13_o = win_q[0][2];
  assign p21_o = win_q[1][0];
  assign p22_o = win_q[1][1];
  assign p23_o = win_q[1][2];
  assign p31_o = win_q[2][0];
  assign p32_o = win_q[2][1];
  assign p33_o = win_q[2][2];

endmodule

// File: rtl/vip_sobel_edge_detector.sv
// Streaming Sobel edge detector, 5-clock latency. Define SOBEL_L2_NORM_EN to
// compare Gx^2+Gy^2 against threshold^2 instead of |Gx|+|Gy| against threshold.
module vip_sobel_edge_detector
  import vip_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_frame_vsync,
  input  logic       pre_frame_href,
  input  logic       pre_frame_clken,
  input  logic [7:0] pre_img_Y,
  input  logic [7:0] Sobel_Threshold,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic       post_img_Bit
);

  localparam int SUM_W = PIX_W + 2;

  logic [PIX_W-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic             s1_vsync, s1_href, s1_clken;

  sobel_matrix_3x3 #(
    .IMG_HDISP(IMG_HDISP),
    .IMG_VDISP(IMG_VDISP)
  ) u_matrix (
    .clk    (clk),
    .rst_n  (rst_n),
    .vsync_i(pre_frame_vsync),
    .href_i (pre_frame_href),
    .clken_i(pre_frame_clken),
    .pix_i  (pre_img_Y),
    .p11_o  (p11), .p12_o(p12), .p13_o(p13),
    .p21_o  (p21), .p22_o(p22), .p23_o(p23),
    .p31_o  (p31), .p32_o(p32), .p33_o(p33),
    .vsync_o(s1_vsync),
    .href_o (s1_href),
    .clken_o(s1_clken)
  );

  // {vsync, href, clken} per stage; index k is the value leaving stage k
  logic [PIPE_LAT:2][2:0]   vld_pipe_q;
  logic [SUM_W-1:0]         gxp_q, gxn_q, gyp_q, gyn_q;
  logic signed [GRAD_W-1:0] gx_d, gy_d;
  logic [GRAD_W-2:0]        ax_q, ay_q;
  logic                     edge_d, bit_q;
`ifdef SOBEL_L2_NORM_EN
  localparam int THR2_W = 2 * PIX_W;
  logic [MAG2_W-1:0] mag_q, mag_d;
  logic [THR2_W-1:0] thr_d;
`else
  logic [MAG_W-1:0]  mag_q, mag_d;
  logic [MAG_W-1:0]  thr_d;
`endif

  always_comb begin
    gx_d = $signed({1'b0, gxp_q}) - $signed({1'b0, gxn_q});
    gy_d = $signed({1'b0, gyp_q}) - $signed({1'b0, gyn_q});
`ifdef SOBEL_L2_NORM_EN
    mag_d  = MAG2_W'(ax_q) * MAG2_W'(ax_q) + MAG2_W'(ay_q) * MAG2_W'(ay_q);
    thr_d  = THR2_W'(Sobel_Threshold) * THR2_W'(Sobel_Threshold);
    edge_d = mag_q > MAG2_W'(thr_d);
`else
    mag_d  = MAG_W'(ax_q) + MAG_W'(ay_q);
    thr_d  = MAG_W'(Sobel_Threshold);
    edge_d = mag_q > thr_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      gxp_q <= '0; gxn_q <= '0; gyp_q <= '0; gyn_q <= '0;
      ax_q  <= '0; ay_q  <= '0;
      mag_q <= '0;
      bit_q <= 1'b0;
    end else begin
      vld_pipe_q[2] <= {s1_vsync, s1_href, s1_clken};
      for (int k = 3; k <= PIPE_LAT; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
      // S2: weighted column / row sums, all unsigned
      gxp_q <= SUM_W'(p13) + SUM_W'({p23, 1'b0}) + SUM_W'(p33);
      gxn_q <= SUM_W'(p11) + SUM_W'({p21, 1'b0}) + SUM_W'(p31);
      gyp_q <= SUM_W'(p11) + SUM_W'({p12, 1'b0}) + SUM_W'(p13);
      gyn_q <= SUM_W'(p31) + SUM_W'({p32, 1'b0}) + SUM_W'(p33);
      // S3 / S4
      ax_q  <= abs_grad(gx_d);
      ay_q  <= abs_grad(gy_d);
      mag_q <= mag_d;
      // S5: gate with the href that lands on post_frame_href in the same edge
      bit_q <= edge_d & vld_pipe_q[PIPE_LAT-1][1];
    end
  end

  assign post_frame_vsync = vld_pipe_q[PIPE_LAT][2];
  assign post_frame_href  = vld_pipe_q[PIPE_LAT][1];
  assign post_frame_clken = vld_pipe_q[PIPE_LAT][0];
  assign post_img_Bit     = bit_q;

endmodule

// File: tb/tb_vip_sobel_edge_detector.sv
// Bench for vip_sobel_edge_detector on a 16x8 frame: directed image table plus
// random frames checked against a 2-D array reference of the Sobel rules.
module tb_vip_sobel_edge_detector;

  localparam int H = 16;
  localparam int V = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pre_frame_vsync = 1'b0;
  logic       pre_frame_href = 1'b0;
  logic       pre_frame_clken = 1'b0;
  logic [7:0] pre_img_Y = 8'd0;
  logic [7:0] Sobel_Threshold = 8'd0;
  logic       post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;

  vip_sobel_edge_detector #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pre_frame_vsync (pre_frame_vsync),
    .pre_frame_href  (pre_frame_href),
    .pre_frame_clken (pre_frame_clken),
    .pre_img_Y       (pre_img_Y),
    .Sobel_Threshold (Sobel_Threshold),
    .post_frame_vsync(post_frame_vsync),
    .post_frame_href (post_frame_href),
    .post_frame_clken(post_frame_clken),
    .post_img_Bit    (post_img_Bit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int frame;
    int r;
    int c;
    int exp;
  } vec_t;

  vec_t       tbl[$];
  int         img[V][H];
  bit         got[H*V];
  bit         exp_q[$];
  logic [2:0] hq[$];
  int         out_cnt = 0;
  bit         chk_bits = 1'b1;
  int         checks = 0;
  int         fails = 0;
  int         pats[6] = '{0, 1, 1, 2, 2, 3};
  int         thrs[6] = '{128, 128, 255, 79, 80, 128};

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pixat(input int r, input int c);
    return (r < 0 || c < 0) ? 0 : img[r][c];
  endfunction

  // Output for the pixel accepted at (r,c): window rows r-2..r, cols c-2..c
  function automatic bit model_bit(input int r, input int c, input int thr);
    int p[3][3];
    int gx, gy;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) p[i][j] = pixat(r - 2 + i, c - 2 + j);
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[0][0] + 2*p[0][1] + p[0][2]) - (p[2][0] + 2*p[2][1] + p[2][2]);
`ifdef SOBEL_L2_NORM_EN
    return (gx*gx + gy*gy) > thr*thr;
`else
    return ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) > thr;
`endif
  endfunction

  function automatic void set_img(input int pat);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        case (pat)
          0:       img[r][c] = 0;
          1:       img[r][c] = (c >= 8) ? 255 : 0;
          2:       img[r][c] = (r == 4 && c == 4) ? 40 : 0;
          3:       img[r][c] = 100;
          default: img[r][c] = ($urandom_range(1) == 0) ? int'($urandom_range(255))
                                                         : (c > 0 ? img[r][c-1] : 50);
        endcase
      end
  endfunction

  // input history sampled on the active edge; outputs equal the entry 5 edges back
  always @(posedge clk) begin
    if (!rst_n) hq.delete();
    else begin
      hq.push_back({pre_frame_vsync, pre_frame_href, pre_frame_clken});
      if (hq.size() > 5) void'(hq.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [2:0] es;
    es = (hq.size() == 5) ? hq[0] : 3'b000;
    check("post_sync", {post_frame_vsync, post_frame_href, post_frame_clken}, es);
    if (!post_frame_href) begin
      check("bit_blank", post_img_Bit, 0);
    end else if (post_frame_clken) begin
      if (chk_bits) begin
        if (exp_q.size() == 0) check("extra_output", 1, 0);
        else check("edge_bit", post_img_Bit, exp_q.pop_front());
      end
      if (out_cnt < H*V) got[out_cnt] = post_img_Bit;
      out_cnt++;
    end
  end

  task automatic drive_line(input int r, input int ncols, input bit gaps);
    for (int c = 0; c < ncols; c++) begin
      if (gaps && $urandom_range(3) == 0) begin
        pre_frame_href = 1'b1; pre_frame_clken = 1'b0; pre_img_Y = 8'($urandom);
        @(negedge clk);
      end
      pre_frame_href = 1'b1; pre_frame_clken = 1'b1; pre_img_Y = 8'(img[r][c]);
      @(negedge clk);
    end
    pre_frame_href = 1'b0; pre_frame_clken = 1'b0; pre_img_Y = 8'd0;
  endtask

  task automatic drive_frame(input int thr, input bit gaps);
    exp_q.delete();
    out_cnt = 0;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) exp_q.push_back(model_bit(r, c, thr));
    Sobel_Threshold = 8'(thr);
    pre_frame_vsync = 1'b0; pre_frame_href = 1'b0; pre_frame_clken = 1'b0;
    repeat (2) @(negedge clk);
    pre_frame_vsync = 1'b1;
    @(negedge clk);
    for (int r = 0; r < V; r++) begin
      drive_line(r, H, gaps);
      repeat (3) @(negedge clk);
    end
    pre_frame_vsync = 1'b0;
    repeat (8) @(negedge clk);
    check("frame_count", out_cnt, H*V);
    check("exp_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{0, 4, 4, 0});  tbl.push_back('{0, 7, 15, 0});
    tbl.push_back('{1, 2, 8, 1});  tbl.push_back('{1, 2, 9, 1});
    tbl.push_back('{1, 2, 7, 0});  tbl.push_back('{1, 2, 10, 0});
    tbl.push_back('{1, 5, 8, 1});  tbl.push_back('{1, 7, 9, 1});
    tbl.push_back('{1, 4, 12, 0});
    tbl.push_back('{2, 3, 8, 1});  tbl.push_back('{2, 6, 9, 1});
    tbl.push_back('{2, 4, 10, 0});
    tbl.push_back('{3, 5, 6, 1});  tbl.push_back('{3, 5, 5, 0});
    tbl.push_back('{4, 5, 6, 0});
    tbl.push_back('{5, 0, 0, 1});  tbl.push_back('{5, 3, 3, 0});
    tbl.push_back('{5, 7, 12, 0});

    repeat (3) @(negedge clk);
    check("reset_vsync", post_frame_vsync, 0);
    check("reset_href", post_frame_href, 0);
    check("reset_clken", post_frame_clken, 0);
    check("reset_bit", post_img_Bit, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int f = 0; f < 6; f++) begin
      set_img(pats[f]);
      drive_frame(thrs[f], 1'b0);
      foreach (tbl[i])
        if (tbl[i].frame == f)
          check($sformatf("vec%0d_f%0d_r%0d_c%0d", i, f, tbl[i].r, tbl[i].c),
                got[tbl[i].r*H + tbl[i].c], tbl[i].exp);
    end

    // random frames back to back with pixel-enable gaps
    for (int f = 0; f < 3; f++) begin
      set_img(4);
      drive_frame(int'($urandom_range(40, 255)), 1'b1);
    end

    // reset in the middle of a line, then the rest of that frame is unchecked
    set_img(4);
    chk_bits = 1'b0;
    Sobel_Threshold = 8'd60;
    pre_frame_vsync = 1'b0;
    repeat (2) @(negedge clk);
    pre_frame_vsync = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      drive_line(r, H, 1'b0);
      repeat (2) @(negedge clk);
    end
    for (int c = 0; c < H/2; c++) begin
      pre_frame_href = 1'b1; pre_frame_clken = 1'b1; pre_img_Y = 8'(img[3][c]);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_vsync", post_frame_vsync, 0);
    check("midrst_href", post_frame_href, 0);
    check("midrst_clken", post_frame_clken, 0);
    check("midrst_bit", post_img_Bit, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pre_frame_href = 1'b0; pre_frame_clken = 1'b0;
    repeat (2) @(negedge clk);
    for (int r = 4; r < 6; r++) begin
      drive_line(r, H, 1'b0);
      repeat (2) @(negedge clk);
    end
    pre_frame_vsync = 1'b0;
    repeat (8) @(negedge clk);
    chk_bits = 1'b1;
    set_img(4);
    drive_frame(int'($urandom_range(40, 255)), 1'b1);
    set_img(4);
    drive_frame(int'($urandom_range(0, 255)), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
